phy_tx_link_ctrl: RTL and testbench

//  Link sequencer in front of the phy_tx datapath, on the clk_2f domain.

---
 rtl/phy_pkg.sv | 15 +
 rtl/phy_lane_enc.sv | 51 +++++
 rtl/phy_tx_link_ctrl.sv | 119 +++++++++++
 tb/tb_phy_tx_link_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared phy link constants: sequencer state encoding and the line symbols
// used by both the tx and rx sides.
package phy_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'b00,
    ST_TRAIN   = 2'b01,
    ST_LINK    = 2'b10,
    ST_ILLEGAL = 2'b11
  } link_state_e;

  localparam logic [7:0] PHY_COM = 8'hBC;
  localparam logic [7:0] PHY_IDL = 8'h7C;

endpackage

// File: rtl/phy_lane_enc.sv
// Per-lane output encoder: registers COM during training, data or IDL fill
// while linked, and an invalid zero word otherwise.
module phy_lane_enc
  import phy_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] COM  = DATA_W'(PHY_COM),
  parameter logic [DATA_W-1:0] IDL  = DATA_W'(PHY_IDL)
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [1:0]        state,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    case (link_state_e'(state))
      ST_TRAIN: begin
        data_d  = COM;
        valid_d = 1'b1;
      end
      ST_LINK: begin
        data_d  = valid_in ? data_in : IDL;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Two-lane tx link sequencer: RESET -> TRAIN (COM burst) -> LINK pass-through,
// with upstream ready gating, saturating drop counter and retrain support.
module phy_tx_link_ctrl
  import phy_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                TRAIN_WORDS = 16,
  parameter logic [DATA_W-1:0] COM         = DATA_W'(PHY_COM),
  parameter logic [DATA_W-1:0] IDL         = DATA_W'(PHY_IDL),
  parameter int                DROP_W      = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              retrain,
  input  logic              valid_data_in_0,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              valid_data_in_1,
  input  logic [DATA_W-1:0] data_in_1,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out_0,
  output logic              valid_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic              valid_out_1,
  output logic              link_up,
  output logic [1:0]        state_out,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int               CNT_W    = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_WORDS - 1);

  link_state_e       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DROP_W-1:0] drop_d, drop_q;
  logic [DROP_W:0]   drop_sum;
  logic              link_st;

  assign link_st = (state_q == ST_LINK);

  // Priority: enable low beats retrain, which beats burst completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
        ST_TRAIN: begin
          if (retrain)               cnt_d   = '0;
          else if (cnt_q == CNT_LAST) state_d = ST_LINK;
          else                       cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_LINK: begin
          if (retrain) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One extra bit catches overflow so the counter sticks at all-ones.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    if (!link_st)
      drop_sum = {1'b0, drop_q} + (DROP_W+1)'(valid_data_in_0)
                                + (DROP_W+1)'(valid_data_in_1);
    drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  phy_lane_enc #(.DATA_W(DATA_W), .COM(COM), .IDL(IDL)) u_lane0 (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .state    (state_q),
    .valid_in (valid_data_in_0),
    .data_in  (data_in_0),
    .data_out (data_out_0),
    .valid_out(valid_out_0)
  );

  phy_lane_enc #(.DATA_W(DATA_W), .COM(COM), .IDL(IDL)) u_lane1 (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .state    (state_q),
    .valid_in (valid_data_in_1),
    .data_in  (data_in_1),
    .data_out (data_out_1),
    .valid_out(valid_out_1)
  );

  assign ready_out = link_st;
  assign link_up   = link_st;
  assign state_out = state_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Randomized and directed bench for phy_tx_link_ctrl against a phase/burst
// reference model.
module tb_phy_tx_link_ctrl;

  localparam int         TW  = 16;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b1;
  logic       enable = 1'b0, retrain = 1'b0;
  logic       vin0 = 1'b0, vin1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       ready_out, valid_out_0, valid_out_1, link_up;
  logic [7:0] data_out_0, data_out_1, drop_cnt;
  logic [1:0] state_out;

  int errs = 0, checks = 0;

  phy_tx_link_ctrl #(.DATA_W(8), .TRAIN_WORDS(TW), .DROP_W(8)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .enable(enable), .retrain(retrain),
    .valid_data_in_0(vin0), .data_in_0(din0),
    .valid_data_in_1(vin1), .data_in_1(din1),
    .ready_out(ready_out), .data_out_0(data_out_0), .valid_out_0(valid_out_0),
    .data_out_1(data_out_1), .valid_out_1(valid_out_1),
    .link_up(link_up), .state_out(state_out), .drop_cnt(drop_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  // Reference model: phase 0=off, 1=training, 2=linked; m_left = training
  // cycles still owed before the link comes up.
  int         m_phase = 0, m_left = 0, m_drop = 0;
  logic       e_v0 = 1'b0, e_v1 = 1'b0;
  logic [7:0] e_d0 = '0, e_d1 = '0;

  always @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      m_phase <= 0; m_left <= 0; m_drop <= 0;
      e_v0 <= 1'b0; e_v1 <= 1'b0; e_d0 <= '0; e_d1 <= '0;
    end else begin
      e_v0 <= (m_phase != 0);
      e_v1 <= (m_phase != 0);
      e_d0 <= (m_phase == 1) ? COM : (m_phase == 2) ? (vin0 ? din0 : IDL) : 8'h00;
      e_d1 <= (m_phase == 1) ? COM : (m_phase == 2) ? (vin1 ? din1 : IDL) : 8'h00;
      if (m_phase != 2)
        m_drop <= (m_drop + int'(vin0) + int'(vin1) > 255) ? 255 : m_drop + int'(vin0) + int'(vin1);
      if (!enable) m_phase <= 0;
      else if (m_phase == 0 || retrain) begin
        m_phase <= 1; m_left <= TW;
      end else if (m_phase == 1) begin
        if (m_left == 1) m_phase <= 2;
        m_left <= m_left - 1;
      end
    end
  end

  logic [29:0] obs_vec, exp_vec;
  assign obs_vec = {ready_out, link_up, state_out, valid_out_0, data_out_0,
                    valid_out_1, data_out_1, drop_cnt};
  assign exp_vec = {m_phase == 2, m_phase == 2, 2'(m_phase), e_v0, e_d0,
                    e_v1, e_d1, 8'(m_drop)};

  task automatic tick();
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic go_link();
    int n = 0;
    enable = 1'b1; retrain = 1'b0;
    while (!link_up && n < 60) begin tick(); n++; end
    checks++;
    if (!link_up) begin errs++; $display("FAIL go_link timeout: link_up=%b want 1", link_up); end
  endtask

  task automatic test_reset();
    #1 reset_L = 1'b0;
    vin0 = 1'b1; vin1 = 1'b1; enable = 1'b1;
    tick(); tick();
    checks++;
    if (obs_vec !== 30'h0) begin errs++; $display("FAIL reset_state: got %h want 0", obs_vec); end
    reset_L = 1'b1; enable = 1'b0; vin0 = 1'b0; vin1 = 1'b0;
    tick();
    checks++;
    if (obs_vec !== exp_vec) begin errs++; $display("FAIL post_reset: got %h want %h", obs_vec, exp_vec); end
  endtask

  task automatic test_train_burst();
    int com_n = 0, rdy_at = -1;
    enable = 1'b1; vin0 = 1'b0; vin1 = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (valid_out_0 && valid_out_1 && data_out_0 == COM && data_out_1 == COM) com_n++;
      if (ready_out && rdy_at < 0) rdy_at = i;
      checks++;
      if (obs_vec !== exp_vec) begin errs++; $display("FAIL train_cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      tick();
    end
    checks++;
    if (com_n != TW) begin errs++; $display("FAIL train_com_count: got %0d want %0d", com_n, TW); end
    checks++;
    if (rdy_at != TW) begin errs++; $display("FAIL train_ready_cycle: got %0d want %0d", rdy_at, TW); end
  endtask

  task automatic test_link_data();
    vin0 = 1'b1; din0 = 8'hA5; vin1 = 1'b0; din1 = 8'h11;
    tick();
    checks++;
    if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== {1'b1, 8'hA5, 1'b1, 8'h7C}) begin
      errs++; $display("FAIL link_lane0_only: got %b %h %b %h want 1 a5 1 7c",
                       valid_out_0, data_out_0, valid_out_1, data_out_1);
    end
    vin0 = 1'b0; din0 = 8'h22; vin1 = 1'b1; din1 = 8'h3C;
    tick();
    checks++;
    if ({valid_out_0, data_out_0, valid_out_1, data_out_1} !== {1'b1, 8'h7C, 1'b1, 8'h3C}) begin
      errs++; $display("FAIL link_lane1_only: got %b %h %b %h want 1 7c 1 3c",
                       valid_out_0, data_out_0, valid_out_1, data_out_1);
    end
    vin1 = 1'b0;
  endtask

  task automatic test_retrain();
    int tr_n = 0;
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (state_out !== 2'b01) begin errs++; $display("FAIL retrain_pre_state: got %b want 01", state_out); end
    retrain = 1'b1; tick(); retrain = 1'b0;
    for (int i = 0; i < 40 && !link_up; i++) begin
      if (state_out == 2'b01) tr_n++;
      checks++;
      if (obs_vec !== exp_vec) begin errs++; $display("FAIL retrain_cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
      tick();
    end
    checks++;
    if (tr_n != TW) begin errs++; $display("FAIL retrain_train_cycles: got %0d want %0d", tr_n, TW); end
    // Retrain from LINK: words offered that cycle still count as accepted.
    vin0 = 1'b1; vin1 = 1'b1; retrain = 1'b1;
    tick();
    retrain = 1'b0; vin0 = 1'b0; vin1 = 1'b0;
    checks++;
    if (obs_vec !== exp_vec) begin errs++; $display("FAIL link_to_train: got %h want %h", obs_vec, exp_vec); end
    tick();
    checks++;
    if (data_out_0 !== COM || data_out_1 !== COM) begin
      errs++; $display("FAIL link_to_train_com: got %h %h want bc bc", data_out_0, data_out_1);
    end
  endtask

  task automatic test_enable_vs_retrain();
    go_link();
    enable = 1'b0; retrain = 1'b1;
    tick();
    retrain = 1'b0;
    checks++;
    if (state_out !== 2'b00 || ready_out !== 1'b0) begin
      errs++; $display("FAIL en_vs_retrain_state: got %b rdy %b want 00 rdy 0", state_out, ready_out);
    end
    tick();
    checks++;
    if (valid_out_0 !== 1'b0 || valid_out_1 !== 1'b0) begin
      errs++; $display("FAIL en_vs_retrain_valid: got %b%b want 00", valid_out_0, valid_out_1);
    end
  endtask

  task automatic test_mid_burst_disable();
    int com_n = 0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    enable = 1'b0;
    tick(); tick();
    checks++;
    if (valid_out_0 !== 1'b0 || state_out !== 2'b00) begin
      errs++; $display("FAIL mid_burst_off: got v%b st%b want v0 st00", valid_out_0, state_out);
    end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (valid_out_1 && data_out_0 == COM && data_out_1 == COM) com_n++;
    end
    checks++;
    if (com_n != TW) begin errs++; $display("FAIL mid_burst_restart: got %0d want %0d", com_n, TW); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      enable  = ($urandom_range(0, 99) < 96);
      retrain = ($urandom_range(0, 99) < 3);
      vin0 = $urandom_range(0, 1); vin1 = $urandom_range(0, 1);
      din0 = 8'($urandom); din1 = 8'($urandom);
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin errs++; $display("FAIL rand_cyc%0d: got %h want %h", i, obs_vec, exp_vec); end
    end
    retrain = 1'b0; vin0 = 1'b0; vin1 = 1'b0;
  endtask

  task automatic test_async_reset();
    go_link();
    @(posedge clk_2f); #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 30'h0) begin errs++; $display("FAIL async_reset: got %h want 0", obs_vec); end
    @(negedge clk_2f);
    reset_L = 1'b1;
  endtask

  task automatic test_drop_sat();
    enable = 1'b0; vin0 = 1'b1; vin1 = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (drop_cnt !== 8'd100) begin errs++; $display("FAIL drop_50: got %0d want 100", drop_cnt); end
    for (int i = 50; i < 300; i++) tick();
    checks++;
    if (drop_cnt !== 8'd255) begin errs++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    checks++;
    if (obs_vec !== exp_vec) begin errs++; $display("FAIL drop_model: got %h want %h", obs_vec, exp_vec); end
  endtask

  initial begin
    test_reset();
    test_train_burst();
    test_link_data();
    test_retrain();
    test_enable_vs_retrain();
    test_mid_burst_disable();
    test_random();
    test_async_reset();
    test_drop_sat();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
